// File: rtl/ext_code_frame_loader.sv
// ext_code_frame_loader: parses framed code lists from a host byte stream,
// buffers a whole frame, verifies its 8-bit checksum and only then replays
// the words to the external code store as isolated write strobes.
// Frame: SOF_BYTE, N, 4*N data bytes (words LSB first), CSUM = sum(N, data).
// Build option: define EXT_CODE_REVERSE_EN to emit buf[N-1] first down to buf[0].
module ext_code_frame_loader #(
  parameter int unsigned MAX_WORDS      = 8,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FLAG_GAP       = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [7:0]  iRX_DATA,
  input  logic        iRX_VALID,
  output logic [31:0] oSET_DATA,
  output logic        oSET_FLAG,
  output logic        oBUSY,
  output logic        oFRAME_OK,
  output logic        oFRAME_ERR,
  output logic [1:0]  oERR_CODE
);

  localparam int unsigned CW = $clog2(MAX_WORDS + 1);
  localparam int unsigned AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = $clog2(FLAG_GAP + 1);

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(FLAG_GAP - 1);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CSUM,
    S_EMIT,
    S_FLAG,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   n_q, n_d;          // words in current frame
  logic [CW-1:0]   idx_q, idx_d;      // write index while receiving, emit count while replaying
  logic [1:0]      bcnt_q, bcnt_d;    // byte position inside current word
  logic [31:0]     word_q, word_d;    // word assembler
  logic [7:0]      acc_q, acc_d;      // running checksum
  logic [TW-1:0]   tmo_q, tmo_d;      // idle cycles since last byte
  logic [GW-1:0]   gap_q, gap_d;      // low cycles elapsed after a strobe
  logic [31:0]     mem_q [MAX_WORDS];
  logic [31:0]     mem_d [MAX_WORDS];

  logic [31:0]     set_data_q, set_data_d;
  logic            set_flag_q, set_flag_d;
  logic            busy_q, busy_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;

  logic [AW-1:0]   rd_addr;
  logic [31:0]     word_full;

  // Buffer read address for the word currently being replayed.
  always_comb begin
`ifdef EXT_CODE_REVERSE_EN
    rd_addr = AW'(n_q - idx_q - CW'(1));
`else
    rd_addr = AW'(idx_q);
`endif
  end

  // Next-state, datapath and output logic for the parse/verify/replay FSM.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    acc_d      = acc_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    mem_d      = mem_q;
    set_data_d = set_data_q;
    set_flag_d = 1'b0;
    busy_d     = busy_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    word_full  = {iRX_DATA, word_q[31:8]};

    unique case (state_q)
      S_IDLE: begin
        if (iRX_VALID && (iRX_DATA == SOF_BYTE)) begin
          state_d = S_COUNT;
          busy_d  = 1'b1;
          code_d  = ERR_NONE;
          acc_d   = '0;
          tmo_d   = '0;
        end
      end

      // Receiving states share the inter-byte timeout; a byte restarts it.
      S_COUNT, S_DATA, S_CSUM: begin
        if (!iRX_VALID) begin
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            code_d  = ERR_TMO;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end else begin
          tmo_d = '0;
          unique case (state_q)
            S_COUNT: begin
              if ((iRX_DATA != 8'd0) && (32'(iRX_DATA) <= MAX_WORDS)) begin
                n_d     = CW'(iRX_DATA);
                acc_d   = iRX_DATA;
                idx_d   = '0;
                bcnt_d  = '0;
                state_d = S_DATA;
              end else begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                code_d  = ERR_COUNT;
                state_d = S_IDLE;
              end
            end
            S_DATA: begin
              acc_d  = acc_q + iRX_DATA;
              word_d = word_full;
              bcnt_d = bcnt_q + 2'd1;
              if (bcnt_q == 2'd3) begin
                mem_d[AW'(idx_q)] = word_full;
                idx_d             = idx_q + CW'(1);
                if ((idx_q + CW'(1)) == n_q) begin
                  state_d = S_CSUM;
                end
              end
            end
            default: begin
              if (iRX_DATA == acc_q) begin
                idx_d   = '0;
                state_d = S_EMIT;
              end else begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                code_d  = ERR_CSUM;
                state_d = S_IDLE;
              end
            end
          endcase
        end
      end

      S_EMIT: begin
        set_data_d = mem_q[rd_addr];
        state_d    = S_FLAG;
      end

      S_FLAG: begin
        set_flag_d = 1'b1;
        gap_d      = '0;
        state_d    = S_GAP;
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if ((idx_q + CW'(1)) == n_q) begin
            ok_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + CW'(1);
            state_d = S_EMIT;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any frame in flight silently.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      acc_q      <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      set_data_q <= '0;
      set_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      acc_q      <= acc_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      set_data_q <= set_data_d;
      set_flag_q <= set_flag_d;
      busy_q     <= busy_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  // Frame buffer; contents are irrelevant after reset so it carries no reset.
  always_ff @(posedge iClk) begin
    mem_q <= mem_d;
  end

  assign oSET_DATA  = set_data_q;
  assign oSET_FLAG  = set_flag_q;
  assign oBUSY      = busy_q;
  assign oFRAME_OK  = ok_q;
  assign oFRAME_ERR = err_q;
  assign oERR_CODE  = code_q;

endmodule

// File: tb/tb_ext_code_frame_loader.sv
// Directed bench for ext_code_frame_loader with a strobe scoreboard.
module tb_ext_code_frame_loader;

  localparam int unsigned GAP = 2;
  localparam int unsigned TMO = 100;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [7:0]  iRX_DATA;
  logic        iRX_VALID;
  logic [31:0] oSET_DATA;
  logic        oSET_FLAG;
  logic        oBUSY;
  logic        oFRAME_OK;
  logic        oFRAME_ERR;
  logic [1:0]  oERR_CODE;

  always #5 iClk = ~iClk;

  ext_code_frame_loader #(
    .MAX_WORDS(8),
    .SOF_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TMO),
    .FLAG_GAP(GAP)
  ) dut (
    .iClk(iClk),
    .iRst(iRst),
    .iRX_DATA(iRX_DATA),
    .iRX_VALID(iRX_VALID),
    .oSET_DATA(oSET_DATA),
    .oSET_FLAG(oSET_FLAG),
    .oBUSY(oBUSY),
    .oFRAME_OK(oFRAME_OK),
    .oFRAME_ERR(oFRAME_ERR),
    .oERR_CODE(oERR_CODE)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned cyc    = 0;
  int unsigned ok_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned err_cyc = 0;
  int unsigned last_tx_cyc = 0;
  exp_t        q[$];
  logic [31:0] w [8];
  logic [31:0] prev_data = '0;
  logic [31:0] hold_data = '0;
  int unsigned hold_cyc = 0;
  bit          hold_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge iClk) cyc <= cyc + 1;

  // Scoreboard monitor: pops expected strobes and watches frame pulses.
  always @(negedge iClk) begin
    exp_t e;
    if (iRst) begin
      hold_pending = 1'b0;
    end else begin
      if (oSET_FLAG) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", 32'(oSET_FLAG), 32'd0);
        end else begin
          e = q.pop_front();
          check("strobe_data", oSET_DATA, e.data);
          check("strobe_cycle", 32'(cyc), 32'(e.cyc));
          check("data_setup", prev_data, e.data);
          hold_cyc     = cyc + GAP;
          hold_data    = e.data;
          hold_pending = 1'b1;
        end
      end
      if (hold_pending && (cyc == hold_cyc)) begin
        check("data_hold", oSET_DATA, hold_data);
        hold_pending = 1'b0;
      end
      if (oFRAME_OK || oFRAME_ERR) begin
        check("ok_err_exclusive", 32'(oFRAME_OK & oFRAME_ERR), 32'd0);
        check("busy_low_at_end", 32'(oBUSY), 32'd0);
      end
      if (oFRAME_OK) ok_cnt++;
      if (oFRAME_ERR) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
    prev_data = oSET_DATA;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge iClk);
    iRX_DATA    = b;
    iRX_VALID   = 1'b1;
    last_tx_cyc = cyc + 1;
    @(negedge iClk);
    iRX_VALID = 1'b0;
  endtask

  // Sends SOF, n, the first n entries of w and a checksum offset by adj;
  // a correct checksum queues the strobes the store should receive.
  task automatic send_frame(input int unsigned n, input logic [7:0] adj);
    logic [7:0]  cs;
    logic [31:0] wv;
    int unsigned c0;
    int unsigned idx;
    send_byte(8'hA5);
    send_byte(8'(n));
    cs = 8'(n);
    for (int unsigned i = 0; i < n; i++) begin
      wv = w[i];
      for (int unsigned b = 0; b < 4; b++) begin
        send_byte(wv[8*b +: 8]);
        cs = cs + wv[8*b +: 8];
      end
    end
    send_byte(cs + adj);
    c0 = last_tx_cyc;
    if (adj == 8'd0) begin
      for (int unsigned k = 0; k < n; k++) begin
`ifdef EXT_CODE_REVERSE_EN
        idx = n - 1 - k;
`else
        idx = k;
`endif
        q.push_back('{w[idx], c0 + 2 + k * (2 + GAP)});
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int unsigned i = 0; (i < 200) && (q.size() != 0); i++) @(negedge iClk);
    check(tag, 32'(q.size()), 32'd0);
    repeat (GAP + 3) @(negedge iClk);
  endtask

  int unsigned ok0;
  int unsigned err0;
  int unsigned t0;

  initial begin
    iRst      = 1'b1;
    iRX_DATA  = '0;
    iRX_VALID = 1'b0;
    repeat (3) @(negedge iClk);
    check("rst_data", oSET_DATA, 32'd0);
    check("rst_flag", 32'(oSET_FLAG), 32'd0);
    check("rst_busy", 32'(oBUSY), 32'd0);
    check("rst_ok", 32'(oFRAME_OK), 32'd0);
    check("rst_err", 32'(oFRAME_ERR), 32'd0);
    check("rst_code", 32'(oERR_CODE), 32'd0);
    iRst = 1'b0;
    repeat (2) @(negedge iClk);

    // Good two-word frame.
    w[0] = 32'h12345678;
    w[1] = 32'hDEADBEEF;
    ok0  = ok_cnt;
    send_byte(8'hA5);
    check("busy_after_sof", 32'(oBUSY), 32'd1);
    send_byte(8'h02);
    for (int unsigned i = 0; i < 2; i++)
      for (int unsigned b = 0; b < 4; b++) begin
        logic [31:0] wv;
        wv = w[i];
        send_byte(wv[8*b +: 8]);
      end
    send_byte(8'h02 + 8'h78 + 8'h56 + 8'h34 + 8'h12 + 8'hEF + 8'hBE + 8'hAD + 8'hDE);
    t0 = last_tx_cyc;
`ifdef EXT_CODE_REVERSE_EN
    q.push_back('{32'hDEADBEEF, t0 + 2});
    q.push_back('{32'h12345678, t0 + 2 + 2 + GAP});
`else
    q.push_back('{32'h12345678, t0 + 2});
    q.push_back('{32'hDEADBEEF, t0 + 2 + 2 + GAP});
`endif
    drain("frame1_drain");
    check("frame1_ok", 32'(ok_cnt - ok0), 32'd1);
    check("frame1_code", 32'(oERR_CODE), 32'd0);

    // Count byte zero, then above MAX_WORDS.
    err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    repeat (3) @(negedge iClk);
    check("cnt0_err", 32'(err_cnt - err0), 32'd1);
    check("cnt0_code", 32'(oERR_CODE), 32'd1);
    err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h09);
    repeat (6) @(negedge iClk);
    check("cnt9_err", 32'(err_cnt - err0), 32'd1);
    check("cnt9_code_sticky", 32'(oERR_CODE), 32'd1);
    check("cnt9_busy", 32'(oBUSY), 32'd0);

    // Recovery with a good single-word frame.
    w[0] = 32'hCAFEF00D;
    ok0  = ok_cnt;
    send_frame(1, 8'd0);
    drain("recover_drain");
    check("recover_ok", 32'(ok_cnt - ok0), 32'd1);
    check("recover_code", 32'(oERR_CODE), 32'd0);

    // Checksum off by one: error, no strobes.
    w[0] = 32'h11111111;
    w[1] = 32'h22222222;
    err0 = err_cnt;
    ok0  = ok_cnt;
    send_frame(2, 8'd1);
    repeat (20) @(negedge iClk);
    check("csum_err", 32'(err_cnt - err0), 32'd1);
    check("csum_code", 32'(oERR_CODE), 32'd2);
    check("csum_no_ok", 32'(ok_cnt - ok0), 32'd0);

    // Stall after three data bytes.
    err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    t0 = last_tx_cyc;
    for (int unsigned i = 0; (i < TMO + 50) && (err_cnt == err0); i++) @(negedge iClk);
    check("tmo_err", 32'(err_cnt - err0), 32'd1);
    check("tmo_cycle", 32'(err_cyc - t0), 32'(TMO));
    check("tmo_code", 32'(oERR_CODE), 32'd3);
    check("tmo_busy", 32'(oBUSY), 32'd0);

    // Reset between strobe 1 and strobe 2 of an eight-word frame.
    for (int unsigned i = 0; i < 8; i++) w[i] = 32'hA0000000 + 32'(i);
    send_frame(8, 8'd0);
    for (int unsigned i = 0; (i < 100) && (q.size() == 8); i++) @(negedge iClk);
    check("rst_first_strobe", 32'(q.size()), 32'd7);
    ok0  = ok_cnt;
    err0 = err_cnt;
    @(negedge iClk);
    #1 iRst = 1'b1;
    #1;
    check("midrst_data", oSET_DATA, 32'd0);
    check("midrst_flag", 32'(oSET_FLAG), 32'd0);
    check("midrst_busy", 32'(oBUSY), 32'd0);
    check("midrst_code", 32'(oERR_CODE), 32'd0);
    q.delete();
    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    repeat (60) @(negedge iClk);
    check("midrst_no_ok", 32'(ok_cnt - ok0), 32'd0);
    check("midrst_no_err", 32'(err_cnt - err0), 32'd0);

    // Junk ahead of SOF, three words; order follows the build option.
    send_byte(8'h00);
    send_byte(8'hFF);
    w[0] = 32'd1;
    w[1] = 32'd2;
    w[2] = 32'd3;
    ok0  = ok_cnt;
    send_frame(3, 8'd0);
    drain("order_drain");
    check("order_ok", 32'(ok_cnt - ok0), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ext_code_frame_loader.md
Name: ext_code_frame_loader

Overview:
- Upstream feeder for the 32-channel, 8-pattern external code store.
- Takes a host byte stream (already deserialised by the UART receiver) and parses framed code lists.
- Buffers each frame and checks its checksum; only then replays the words as clean iSET_FLAG/iSET_DATA write strobes.
- Guarantees the code store never sees a partial or corrupted frame, and that every write strobe is a single, well-separated pulse with stable data.

Parameters:
- MAX_WORDS, 8: maximum words per frame; buffer depth. Word counter width is clog2(MAX_WORDS+1).
- SOF_BYTE, 8'hA5: start-of-frame marker.
- TIMEOUT_CYCLES, 50000: maximum idle iClk cycles allowed between bytes inside a frame.
- FLAG_GAP, 2: low cycles after each oSET_FLAG pulse before the next word is presented (minimum 1).

Ports:
- iClk  in  1  system clock; all logic on its rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iRX_DATA  in  8  received byte.
- iRX_VALID  in  1  one-cycle strobe; iRX_DATA is valid this cycle.
- oSET_DATA  out  32  code word to the store.
- oSET_FLAG  out  1  one-cycle write strobe to the store.
- oBUSY  out  1  high from SOF acceptance until frame end or abort.
- oFRAME_OK  out  1  one-cycle pulse after the last word of a good frame is emitted.
- oFRAME_ERR  out  1  one-cycle pulse on frame abort.
- oERR_CODE  out  2  last error: 0 none, 1 bad count, 2 checksum, 3 timeout. Sticky until the next SOF is accepted.

Behaviour:
- Reset (async, iRst=1): all outputs 0; FSM goes to IDLE; counters and checksum accumulator cleared. Buffer contents are don't-care. A reset mid-frame or mid-emit aborts with no further strobes, and no FRAME_OK or FRAME_ERR pulse is generated.
- Frame format: SOF_BYTE, N, then 4*N data bytes (each word LSB first), then CSUM. CSUM = 8-bit sum (mod 256) of N and all data bytes.
- IDLE:
  - VALID with byte == SOF_BYTE -> COUNT. Set oBUSY, clear oERR_CODE and the accumulator.
  - Any other byte is silently dropped.
- COUNT, on VALID:
  - N in 1..MAX_WORDS -> store N, acc = N, -> DATA.
  - Otherwise: FRAME_ERR pulse, code 1, -> IDLE.
- DATA, on VALID:
  - Shift the byte into the word assembler; acc += byte.
  - After the 4th byte, write the word to buf[word_idx] and increment word_idx.
  - After word N is complete -> CSUM.
- CSUM, on VALID:
  - byte == acc -> EMIT.
  - Otherwise: FRAME_ERR pulse, code 2, -> IDLE.
- Timeout: in COUNT, DATA and CSUM, a counter clears on every VALID and increments otherwise. When it reaches TIMEOUT_CYCLES: FRAME_ERR pulse, code 3, -> IDLE.
- EMIT / FLAG / GAP loop, for each word:
  - EMIT cycle: oSET_DATA <= word.
  - Next cycle: oSET_FLAG = 1.
  - Then FLAG_GAP cycles with oSET_FLAG = 0; oSET_DATA is held throughout.
  - Data is stable at least 1 cycle before and FLAG_GAP cycles after each strobe.
- Word order: buf[0] first (default).
- Latency: CSUM accepted at cycle c -> first data at c+1, first strobe at c+2. Word k strobe at c+2+k*(2+FLAG_GAP).
- End of frame: after the last GAP, FRAME_OK pulses in the same cycle oBUSY drops, then -> IDLE. oSET_DATA holds the last word until the next emit.
- Bytes arriving during EMIT/FLAG/GAP are dropped; the host must respect oBUSY. FRAME_OK and FRAME_ERR never assert together.
- oBUSY drops in the cycle that FRAME_ERR pulses.

Optional Feature:
- Macro EXT_CODE_REVERSE_EN.
- Defined: words are emitted buf[N-1] first down to buf[0], so the first word received is the last one written.
- Undefined: emit order is buf[0] first.
- Framing, checksum and timing are identical in both builds.

Test Plan:
- Good frame A5,02, 78 56 34 12, EF BE AD DE, CSUM=0x?? (correct sum) -> strobes with 0x12345678 then 0xDEADBEEF, spaced 4 cycles (FLAG_GAP=2); FRAME_OK once; oERR_CODE=0.
- Count byte 00, then separately 09 (with MAX_WORDS=8) -> FRAME_ERR, oERR_CODE=1, no strobes; the following good frame is accepted.
- Good frame with CSUM off by 1 -> FRAME_ERR, code 2, zero strobes.
- Frame stalled after 3 data bytes for TIMEOUT_CYCLES (set to 100) -> FRAME_ERR at cycle 100, code 3, oBUSY=0.
- iRst asserted between strobe 1 and strobe 2 of an 8-word frame -> all outputs 0 immediately, no further strobes, no OK/ERR pulse.
- EXT_CODE_REVERSE_EN defined, words 1,2,3 -> strobe order 3,2,1; junk bytes 00 FF before SOF are ignored.
